mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, meaning memory-wait cycles tolerated before fault (legal 1..255).
REQ-002 SHALL have port CLK  input  1  rising-edge clock; the block uses one clock.
REQ-003 SHALL have port resetl  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port Opcode  input  11  instruction bits [31:21] from the instruction register.
REQ-005 SHALL have port Zero  input  1  ALU zero flag.
REQ-006 SHALL have port MemReady  input  1  memory completes the requested access this cycle.
REQ-007 SHALL have port IRWrite  output  1  instruction register load strobe.
REQ-008 SHALL have port PCWrite  output  1  PC load strobe.
REQ-009 SHALL have port MemRead  output  1  memory read request.
REQ-010 SHALL have port MemWrite  output  1  memory write request.
REQ-011 SHALL have port RegWrite  output  1  register file write strobe.
REQ-012 SHALL have port MemtoReg  output  1  writeback source select: 1 = memory, 0 = ALU.
REQ-013 SHALL have port Reg2Loc  output  1  read port 2 select: 1 = Rt.
REQ-014 SHALL have port ALUSrcB  output  2  ALU B operand select: 00 = register, 01 = constant 4, 10 = sign-extended immediate.
REQ-015 SHALL have port ALUOp  output  2  to ALU control: 00 = add, 01 = pass-B, 10 = R-type by opcode.
REQ-016 SHALL have port PCSrc  output  2  PC source: 00 = PC+4, 01 = CBZ target, 10 = B target.
REQ-017 SHALL have port Fault  output  1  sticky illegal-opcode or timeout indicator.
REQ-018 SHALL have port State  output  4  current state code.
REQ-019 SHALL have port instr_count  output  32  retired instructions; present only with PERF_CNT_EN.

Function
REQ-020 State codes SHALL be: FETCH=0, DECODE=1, EXEC_R=2, WB_R=3, ADDR=4, MEM_RD=5, WB_LD=6, MEM_WR=7, CBZ=8, B=9, FAULT=10.
REQ-021 Each output SHALL be 0 in every state that does not assign it.
REQ-022 FETCH SHALL drive MemRead=1, ALUSrcB=01, ALUOp=00; when MemReady=1 it SHALL pulse IRWrite=1 and PCWrite=1 with PCSrc=00, and go to DECODE; otherwise it SHALL hold.
REQ-023 DECODE SHALL latch an opcode class and transition as follows: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC_R; LDUR 11111000010 or STUR 11111000000 -> ADDR; Opcode[10:3]=10110100 -> CBZ; Opcode[10:5]=000101 -> B; any other value -> FAULT.
REQ-024 States after DECODE SHALL use only the latched class and SHALL ignore later Opcode changes.
REQ-025 EXEC_R SHALL drive ALUSrcB=00, ALUOp=10 and go to WB_R; WB_R SHALL drive ALUOp=10, RegWrite=1, MemtoReg=0 and go to FETCH.
REQ-026 ADDR SHALL drive ALUSrcB=10, ALUOp=00 and go to MEM_RD for LDUR or MEM_WR for STUR.
REQ-027 MEM_RD SHALL drive MemRead=1, ALUSrcB=10, ALUOp=00 and go to WB_LD when MemReady=1; WB_LD SHALL drive RegWrite=1, MemtoReg=1 and go to FETCH.
REQ-028 MEM_WR SHALL drive MemWrite=1, Reg2Loc=1, ALUSrcB=10, ALUOp=00 and go to FETCH when MemReady=1.
REQ-029 CBZ SHALL drive Reg2Loc=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCWrite=Zero (combinational), and go to FETCH.
REQ-030 B SHALL drive PCWrite=1, PCSrc=10 and go to FETCH.
REQ-031 FAULT SHALL hold Fault=1 with all strobes 0 until reset.
REQ-032 A wait counter SHALL clear on entry to FETCH, MEM_RD and MEM_WR, and SHALL increment each cycle those states see MemReady=0.
REQ-033 When the wait counter equals MAX_WAIT and MemReady=0, the next state SHALL be FAULT; if MemReady=1 in that same cycle, the access SHALL complete normally.

Reset
REQ-034 While resetl=0: State SHALL be FETCH; wait counter, latched class, Fault and instr_count SHALL be 0; all strobes SHALL be forced to 0.
REQ-035 Reset assertion mid-access SHALL abort immediately with no strobe glitch; the first fetch request SHALL follow the first CLK edge after deassertion.

Configuration
REQ-036 With PERF_CNT_EN defined, instr_count SHALL increment by 1 on each return to FETCH from WB_R, WB_LD, MEM_WR, CBZ or B, and SHALL wrap 0xFFFFFFFF -> 0; without the macro, the port and its logic SHALL be absent.

Verification
REQ-037 ADD 10001011000 with MemReady always 1 -> states 0,1,2,3,0; RegWrite=1 only in WB_R; instr_count=1.
REQ-038 LDUR with MemReady low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then WB_LD with MemtoReg=1 and RegWrite=1.
REQ-039 CBZ with Zero=1 -> PCWrite=1 and PCSrc=01 in CBZ; with Zero=0 -> PCWrite=0.
REQ-040 Opcode 11111111111 at DECODE -> FAULT; Fault=1 persists for 20 cycles; resetl pulse -> State=0, Fault=0.
REQ-041 MAX_WAIT=15 with MemReady held 0 in FETCH -> FAULT after 15 wait cycles; same run with MemReady=1 on the 15th wait cycle -> DECODE.

Source files
------------

// File: rtl/mc_control_fsm.sv
// ----------------------------------------------------------------------------
// mc_control_fsm
// Multi-cycle control unit for a small ARMv8-subset datapath. It sequences
// fetch, decode, R-type execute/writeback, LDUR/STUR address and memory
// phases, CBZ and B, and locks into a sticky FAULT state on an illegal opcode
// or when memory stalls longer than MAX_WAIT cycles.
//
// Optional feature: define PERF_CNT_EN to add the instr_count port, a 32-bit
// wrapping count of retired instructions.
//
// Ports
//   CLK          rising-edge clock
//   resetl       asynchronous active-low reset
//   Opcode[10:0] instruction bits [31:21]
//   Zero         ALU zero flag (used by CBZ)
//   MemReady     memory completes the requested access this cycle
//   IRWrite, PCWrite, MemRead, MemWrite, RegWrite   strobes
//   MemtoReg, Reg2Loc, ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0]   selects
//   Fault        sticky fault indicator
//   State[3:0]   current state code
//   instr_count  retired instructions (PERF_CNT_EN only)
// ----------------------------------------------------------------------------
module mc_control_fsm #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        CLK,
   input  logic        resetl,
   input  logic [10:0] Opcode,
   input  logic        Zero,
   input  logic        MemReady,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        MemtoReg,
   output logic        Reg2Loc,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUOp,
   output logic [1:0]  PCSrc,
   output logic        Fault,
   output logic [3:0]  State
`ifdef PERF_CNT_EN
   ,
   output logic [31:0] instr_count
`endif
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_WB_R   = 4'd3,
      S_ADDR   = 4'd4,
      S_MEM_RD = 4'd5,
      S_WB_LD  = 4'd6,
      S_MEM_WR = 4'd7,
      S_CBZ    = 4'd8,
      S_B      = 4'd9,
      S_FAULT  = 4'd10
   } state_t;

   typedef enum logic [2:0] {
      C_NONE  = 3'd0,
      C_RTYPE = 3'd1,
      C_LOAD  = 3'd2,
      C_STORE = 3'd3,
      C_CBZ   = 3'd4,
      C_B     = 3'd5
   } cls_t;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   state_t      state_q, state_d;
   cls_t        cls_q, cls_d;
   logic [7:0]  wait_q, wait_d;
   logic        fault_q, fault_d;
   // run_q holds every output quiet until the first clock edge after reset
   // release, so the fetch request cannot appear asynchronously with resetl.
   logic        run_q, run_d;
   logic        mem_wait;
`ifdef PERF_CNT_EN
   logic [31:0] cnt_q, cnt_d;
`endif

   function automatic cls_t decode_op(input logic [10:0] op);
      cls_t c;
      casez (op)
         11'b10001011000,
         11'b11001011000,
         11'b10001010000,
         11'b10101010000: c = C_RTYPE;
         11'b11111000010: c = C_LOAD;
         11'b11111000000: c = C_STORE;
         11'b10110100???: c = C_CBZ;
         11'b000101?????: c = C_B;
         default:         c = C_NONE;
      endcase
      return c;
   endfunction

   assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);

   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      wait_d  = wait_q;
      fault_d = fault_q;
      run_d   = 1'b1;
`ifdef PERF_CNT_EN
      cnt_d   = cnt_q;
`endif
      if (run_q) begin
         case (state_q)
            S_FETCH:  if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
               cls_d = decode_op(Opcode);
               case (cls_d)
                  C_RTYPE:         state_d = S_EXEC_R;
                  C_LOAD, C_STORE: state_d = S_ADDR;
                  C_CBZ:           state_d = S_CBZ;
                  C_B:             state_d = S_B;
                  default:         state_d = S_FAULT;
               endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_WB_R:   state_d = S_FETCH;
            S_ADDR:   state_d = (cls_q == C_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (MemReady) state_d = S_WB_LD;
            S_WB_LD:  state_d = S_FETCH;
            S_MEM_WR: if (MemReady) state_d = S_FETCH;
            S_CBZ:    state_d = S_FETCH;
            S_B:      state_d = S_FETCH;
            default:  state_d = S_FAULT;
         endcase

         // A completing access in the limit cycle still wins over timeout.
         if (mem_wait && !MemReady) begin
            if (wait_q == MAX_WAIT_C) state_d = S_FAULT;
            else                      wait_d  = wait_q + 8'd1;
         end
         // Any state change clears the counter, covering entry to every
         // waiting state.
         if (state_d != state_q) wait_d = '0;
         if (state_d == S_FAULT) fault_d = 1'b1;
`ifdef PERF_CNT_EN
         // Only retiring states ever move into FETCH.
         if ((state_d == S_FETCH) && (state_q != S_FETCH)) cnt_d = cnt_q + 32'd1;
`endif
      end
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q <= S_FETCH;
         cls_q   <= C_NONE;
         wait_q  <= '0;
         fault_q <= 1'b0;
         run_q   <= 1'b0;
`ifdef PERF_CNT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         wait_q  <= wait_d;
         fault_q <= fault_d;
         run_q   <= run_d;
`ifdef PERF_CNT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Outputs decode the state flops; IRWrite/PCWrite also follow MemReady
   // and Zero within the cycle so strobes land on the completing cycle.
   always_comb begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      MemtoReg = 1'b0;
      Reg2Loc  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      PCSrc    = 2'b00;
      if (run_q) begin
         case (state_q)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = MemReady;
               PCWrite = MemReady;
            end
            S_EXEC_R: ALUOp = 2'b10;
            S_WB_R: begin
               ALUOp    = 2'b10;
               RegWrite = 1'b1;
            end
            S_ADDR: ALUSrcB = 2'b10;
            S_MEM_RD: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_WB_LD: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
               MemWrite = 1'b1;
               Reg2Loc  = 1'b1;
               ALUSrcB  = 2'b10;
            end
            S_CBZ: begin
               Reg2Loc = 1'b1;
               ALUOp   = 2'b01;
               PCSrc   = 2'b01;
               PCWrite = Zero;
            end
            S_B: begin
               PCWrite = 1'b1;
               PCSrc   = 2'b10;
            end
            default: ;
         endcase
      end
   end

   assign Fault = fault_q;
   assign State = state_q;
`ifdef PERF_CNT_EN
   assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_mc_control_fsm
// Scoreboard bench for mc_control_fsm: every driven cycle pushes the expected
// state, output vector, Fault (and instr_count with PERF_CNT_EN) into a queue;
// a monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_mc_control_fsm;

   logic        CLK;
   logic        resetl;
   logic [10:0] Opcode;
   logic        Zero;
   logic        MemReady;
   logic        IRWrite, PCWrite, MemRead, MemWrite, RegWrite, MemtoReg, Reg2Loc;
   logic [1:0]  ALUSrcB, ALUOp, PCSrc;
   logic        Fault;
   logic [3:0]  State;
`ifdef PERF_CNT_EN
   logic [31:0] instr_count;
`endif

   mc_control_fsm #(.MAX_WAIT(15)) dut (
      .CLK(CLK), .resetl(resetl), .Opcode(Opcode), .Zero(Zero),
      .MemReady(MemReady), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .MemtoReg(MemtoReg), .Reg2Loc(Reg2Loc), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .PCSrc(PCSrc), .Fault(Fault), .State(State)
`ifdef PERF_CNT_EN
      , .instr_count(instr_count)
`endif
   );

   localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC = 4'd2,
      S_WBR = 4'd3, S_ADDR = 4'd4, S_MRD = 4'd5, S_WBLD = 4'd6, S_MWR = 4'd7,
      S_CBZ = 4'd8, S_B = 4'd9, S_FAULT = 4'd10;

   // ir pw mr mw rw m2r r2l | ALUSrcB | ALUOp | PCSrc
   localparam logic [12:0] O_IDLE       = 13'b0_0_0_0_0_0_0_00_00_00;
   localparam logic [12:0] O_FETCH_WAIT = 13'b0_0_1_0_0_0_0_01_00_00;
   localparam logic [12:0] O_FETCH_GO   = 13'b1_1_1_0_0_0_0_01_00_00;
   localparam logic [12:0] O_EXEC       = 13'b0_0_0_0_0_0_0_00_10_00;
   localparam logic [12:0] O_WBR        = 13'b0_0_0_0_1_0_0_00_10_00;
   localparam logic [12:0] O_ADDR       = 13'b0_0_0_0_0_0_0_10_00_00;
   localparam logic [12:0] O_MRD        = 13'b0_0_1_0_0_0_0_10_00_00;
   localparam logic [12:0] O_WBLD       = 13'b0_0_0_0_1_1_0_00_00_00;
   localparam logic [12:0] O_MWR        = 13'b0_0_0_1_0_0_1_10_00_00;
   localparam logic [12:0] O_CBZ1       = 13'b0_1_0_0_0_0_1_00_01_01;
   localparam logic [12:0] O_CBZ0       = 13'b0_0_0_0_0_0_1_00_01_01;
   localparam logic [12:0] O_B          = 13'b0_1_0_0_0_0_0_00_00_10;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100101;
   localparam logic [10:0] OP_B    = 11'b00010110011;
   localparam logic [10:0] OP_BAD  = 11'b11111111111;

   typedef struct packed {
      logic [3:0]  st;
      logic [12:0] ou;
      logic        f;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb[$];
   string       tag_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_cnt = 0;
   logic [12:0] outs_w;

   assign outs_w = {IRWrite, PCWrite, MemRead, MemWrite, RegWrite, MemtoReg,
                    Reg2Loc, ALUSrcB, ALUOp, PCSrc};

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         exp_t  e;
         string t;
         e = sb.pop_front();
         t = tag_q.pop_front();
         check_eq({t, ".state"}, 32'(State), 32'(e.st));
         check_eq({t, ".outs"},  32'(outs_w), 32'(e.ou));
         check_eq({t, ".fault"}, 32'(Fault), 32'(e.f));
`ifdef PERF_CNT_EN
         check_eq({t, ".icnt"},  instr_count, e.cnt);
`endif
      end
   end

   // One clock cycle: drive inputs just after the rising edge and queue
   // what the DUT must show for the rest of that cycle.
   task automatic cyc(input logic rl, input logic mr, input logic z,
                      input logic [10:0] op, input logic [3:0] st,
                      input logic [12:0] ou, input logic f, input string tag);
      exp_t e;
      @(posedge CLK);
      #1;
      resetl   = rl;
      MemReady = mr;
      Zero     = z;
      Opcode   = op;
      e.st = st; e.ou = ou; e.f = f; e.cnt = exp_cnt;
      sb.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic run_r(input logic [10:0] op);
      cyc(1, 1, 0, op,     S_FETCH,  O_FETCH_GO, 0, "r_fetch");
      cyc(1, 0, 0, op,     S_DECODE, O_IDLE,     0, "r_dec");
      cyc(1, 1, 1, OP_BAD, S_EXEC,   O_EXEC,     0, "r_exec");
      cyc(1, 0, 0, OP_BAD, S_WBR,    O_WBR,      0, "r_wb");
      exp_cnt++;
   endtask

   task automatic run_ld(input int fw, input int mw);
      for (int i = 0; i < fw; i++)
         cyc(1, 0, 0, OP_LDUR, S_FETCH, O_FETCH_WAIT, 0, "ld_fwait");
      cyc(1, 1, 0, OP_LDUR, S_FETCH,  O_FETCH_GO, 0, "ld_fetch");
      cyc(1, 0, 0, OP_LDUR, S_DECODE, O_IDLE,     0, "ld_dec");
      cyc(1, 0, 0, OP_STUR, S_ADDR,   O_ADDR,     0, "ld_addr");
      for (int i = 0; i < mw; i++)
         cyc(1, 0, 0, OP_STUR, S_MRD, O_MRD, 0, "ld_mwait");
      cyc(1, 1, 0, OP_STUR, S_MRD,  O_MRD,  0, "ld_mdone");
      cyc(1, 0, 0, OP_STUR, S_WBLD, O_WBLD, 0, "ld_wb");
      exp_cnt++;
   endtask

   task automatic run_st();
      cyc(1, 1, 0, OP_STUR, S_FETCH,  O_FETCH_GO, 0, "st_fetch");
      cyc(1, 0, 0, OP_STUR, S_DECODE, O_IDLE,     0, "st_dec");
      cyc(1, 0, 0, OP_LDUR, S_ADDR,   O_ADDR,     0, "st_addr");
      cyc(1, 0, 0, OP_LDUR, S_MWR,    O_MWR,      0, "st_mwait");
      cyc(1, 0, 0, OP_LDUR, S_MWR,    O_MWR,      0, "st_mwait");
      cyc(1, 1, 0, OP_LDUR, S_MWR,    O_MWR,      0, "st_mdone");
      exp_cnt++;
   endtask

   task automatic run_cbz(input logic z);
      cyc(1, 1, 0, OP_CBZ, S_FETCH,  O_FETCH_GO, 0, "cbz_fetch");
      cyc(1, 0, 0, OP_CBZ, S_DECODE, O_IDLE,     0, "cbz_dec");
      cyc(1, 0, z, OP_BAD, S_CBZ, z ? O_CBZ1 : O_CBZ0, 0, "cbz_exec");
      exp_cnt++;
   endtask

   task automatic run_b();
      cyc(1, 1, 0, OP_B,   S_FETCH,  O_FETCH_GO, 0, "b_fetch");
      cyc(1, 0, 0, OP_B,   S_DECODE, O_IDLE,     0, "b_dec");
      cyc(1, 0, 0, OP_BAD, S_B,      O_B,        0, "b_exec");
      exp_cnt++;
   endtask

   task automatic reset_pulse();
      exp_cnt = 0;
      cyc(0, 1, 0, OP_ADD, S_FETCH, O_IDLE, 0, "rst_on");
      cyc(1, 1, 0, OP_ADD, S_FETCH, O_IDLE, 0, "rst_rel");
   endtask

   initial begin
      resetl   = 1'b0;
      MemReady = 1'b0;
      Zero     = 1'b0;
      Opcode   = '0;

      cyc(0, 0, 0, OP_ADD, S_FETCH, O_IDLE, 0, "rst");
      cyc(0, 1, 1, OP_ADD, S_FETCH, O_IDLE, 0, "rst");
      cyc(1, 1, 0, OP_ADD, S_FETCH, O_IDLE, 0, "rst_rel");

      run_r(OP_ADD);
      run_ld(0, 3);
      run_st();
      run_cbz(1'b1);
      run_cbz(1'b0);
      run_b();
      run_r(OP_SUB);
      run_r(OP_AND);
      run_r(OP_ORR);
      run_ld(10, 15);
      cyc(1, 0, 0, OP_ADD, S_FETCH, O_FETCH_WAIT, 0, "cnt_fetch");

      // Illegal opcode: sticky fault until reset.
      cyc(1, 1, 0, OP_BAD, S_FETCH,  O_FETCH_GO, 0, "bad_fetch");
      cyc(1, 0, 0, OP_BAD, S_DECODE, O_IDLE,     0, "bad_dec");
      for (int i = 0; i < 20; i++)
         cyc(1, 1'(i), 1'(i), OP_ADD, S_FAULT, O_IDLE, 1, "bad_hold");
      reset_pulse();

      // Fetch timeout: 15 counted stalls, then the limit cycle still stalled.
      for (int i = 0; i < 16; i++)
         cyc(1, 0, 0, OP_ADD, S_FETCH, O_FETCH_WAIT, 0, "to_wait");
      cyc(1, 0, 0, OP_ADD, S_FAULT, O_IDLE, 1, "to_fault");
      cyc(1, 1, 0, OP_ADD, S_FAULT, O_IDLE, 1, "to_fault");
      reset_pulse();

      // Same run, memory answers in the limit cycle.
      for (int i = 0; i < 15; i++)
         cyc(1, 0, 0, OP_ADD, S_FETCH, O_FETCH_WAIT, 0, "lim_wait");
      cyc(1, 1, 0, OP_ADD, S_FETCH,  O_FETCH_GO, 0, "lim_go");
      cyc(1, 0, 0, OP_ADD, S_DECODE, O_IDLE,     0, "lim_dec");
      cyc(1, 0, 0, OP_ADD, S_EXEC,   O_EXEC,     0, "lim_exec");
      cyc(1, 0, 0, OP_ADD, S_WBR,    O_WBR,      0, "lim_wb");
      exp_cnt++;
      cyc(1, 0, 0, OP_ADD, S_FETCH,  O_FETCH_WAIT, 0, "lim_fetch");

      repeat (2) @(posedge CLK);
      check_eq("sb_drain", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
